// File: rtl/seg_scan4_pkg.sv
// Shared definitions for the seg_scan4 display driver: segment and digit
// encodings, scan FSM states and the leading-zero test helper.
package seg_scan4_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] DIG_OFF = 4'b1111;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when digit pos and every digit above it are zero (digit 0 never qualifies).
    function automatic logic lz_suppress(input logic [15:0] val, input logic [1:0] pos);
        logic res;
        res = 1'b0;
        case (pos)
            2'd1:    res = (val[15:4] == 12'h000);
            2'd2:    res = (val[15:8] == 8'h00);
            2'd3:    res = (val[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to active-low seven-segment (gfedcba) decoder.
module seg_hex_decode
    import seg_scan4_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and
// per-frame input snapshot. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan4
    import seg_scan4_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  dig_an,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow_din;
    logic [3:0]       shadow_dp;
    scan_state_t      state;
    scan_state_t      state_nxt;
    logic             slot_wrap;
    logic             frame_start;
    logic             show;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_start = (slot_cnt == '0) && (idx == 2'd0);
    assign nibble      = shadow_din[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // The snapshot is taken only at frame start so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            slot_cnt   <= '0;
            idx        <= 2'd0;
            shadow_din <= 16'h0000;
            shadow_dp  <= 4'h0;
            state      <= ST_BLANK;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                idx <= idx + 2'd1;
            end
            if (frame_start) begin
                shadow_din <= din;
                shadow_dp  <= dp_in;
            end
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BLANK: begin
                if (BLANK_CYC == 0 || slot_cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (BLANK_CYC > 0 && slot_wrap) begin
                    state_nxt = ST_BLANK;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        show = (state == ST_SHOW);
`ifdef SEG_LZB_EN
        if (lz_suppress(shadow_din, idx)) begin
            show = 1'b0;
        end
`endif
    end

    // Pins are registered so the display sees glitch-free levels one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            seg_out    <= SEG_OFF;
            dp_out     <= 1'b1;
            dig_an     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (show) begin
                seg_out <= dec_seg;
                dp_out  <= ~shadow_dp[idx];
                dig_an  <= ~(4'b0001 << idx);
            end else begin
                seg_out <= SEG_OFF;
                dp_out  <= 1'b1;
                dig_an  <= DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan4.sv
// Randomized bench for seg_scan4: two instances (BLANK_CYC=2 and 0) compared
// every cycle against a time-indexed behavioural model of the display scan.
module tb_seg_scan4;

    localparam int P     = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * P;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       tick;
    } pins_t;

    localparam pins_t PINS_RST = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, tick: 1'b0};

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        tick0, tick1;

    int checks   = 0;
    int failures = 0;

    seg_scan4 #(.PRESCALE(P), .BLANK_CYC(BLANK)) u_dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .din        (din),
        .dp_in      (dp_in),
        .seg_out    (seg0),
        .dp_out     (dp0),
        .dig_an     (an0),
        .frame_tick (tick0)
    );

    seg_scan4 #(.PRESCALE(P), .BLANK_CYC(0)) u_dut_nb (
        .clk        (clk),
        .clr_n      (clr_n),
        .din        (din),
        .dp_in      (dp_in),
        .seg_out    (seg1),
        .dp_out     (dp1),
        .dig_an     (an1),
        .frame_tick (tick1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Pins expected one cycle after the scan has run n cycles since reset,
    // given the snapshot that was current during that cycle.
    function automatic pins_t ref_pins(input int n, input int blank, input logic [15:0] sd, input logic [3:0] sdp);
        pins_t p;
        int    slot;
        int    dig;
        bit    lit;
        p    = PINS_RST;
        slot = n % P;
        dig  = (n / P) % 4;
        p.tick = ((n % FRAME) == 0);
        lit  = (n > 0) && (slot >= blank);
`ifdef SEG_LZB_EN
        if (dig >= 1 && (sd >> (4 * dig)) == 16'h0000) lit = 1'b0;
`endif
        if (lit) begin
            p.seg     = HEX_TAB[sd[4*dig +: 4]];
            p.dp      = ~sdp[dig];
            p.an      = 4'hF;
            p.an[dig] = 1'b0;
        end
        return p;
    endfunction

    int          n_m      = 0;
    logic [15:0] snap_din = 16'h0000;
    logic [3:0]  snap_dp  = 4'h0;
    pins_t       exp0, exp1;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (!clr_n) begin
            exp0     <= PINS_RST;
            exp1     <= PINS_RST;
            n_m      <= 0;
            snap_din <= 16'h0000;
            snap_dp  <= 4'h0;
            model_ok <= 1'b1;
        end else begin
            exp0 <= ref_pins(n_m, BLANK, snap_din, snap_dp);
            exp1 <= ref_pins(n_m, 0, snap_din, snap_dp);
            if ((n_m % FRAME) == 0) begin
                snap_din <= din;
                snap_dp  <= dp_in;
            end
            n_m <= n_m + 1;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("seg_b2",  16'(seg0),  16'(exp0.seg));
            checkOutput("dp_b2",   16'(dp0),   16'(exp0.dp));
            checkOutput("an_b2",   16'(an0),   16'(exp0.an));
            checkOutput("tick_b2", 16'(tick0), 16'(exp0.tick));
            checkOutput("seg_b0",  16'(seg1),  16'(exp1.seg));
            checkOutput("dp_b0",   16'(dp1),   16'(exp1.dp));
            checkOutput("an_b0",   16'(an1),   16'(exp1.an));
            checkOutput("tick_b0", 16'(tick1), 16'(exp1.tick));
            checkOutput("onehot_b2", 16'($countones(~an0) <= 1), 16'd1);
            checkOutput("onehot_b0", 16'($countones(~an1) <= 1), 16'd1);
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input int cycles);
        din   = d;
        dp_in = p;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        clr_n = 1'b0;
        din   = 16'hFFFF;
        dp_in = 4'hF;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;

        applyStimulus(16'h1234, 4'b0100, 2 * FRAME + 19);
        applyStimulus(16'hABCD, 4'b0001, FRAME + 13);

        for (int i = 0; i < 2 * FRAME && (n_m % FRAME) != 26; i++) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        applyStimulus(16'h5E6F, 4'b1010, 2 * FRAME);

        applyStimulus(16'h0042, 4'b1111, 2 * FRAME);
        applyStimulus(16'h0000, 4'b1111, 2 * FRAME);
        applyStimulus(16'h0700, 4'b0110, 2 * FRAME);

        repeat (600) begin
            if ($urandom_range(0, 9) == 0) din = 16'($urandom);
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            clr_n = ($urandom_range(0, 149) != 0);
            @(negedge clk);
        end
        clr_n = 1'b1;
        repeat (FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
